// File: rtl/overlay_pkg.sv
// overlay_pkg: overlay word layout shared by the overlay generator and the framebuffer writer
package overlay_pkg;
  localparam int WORD_W     = 54;
  localparam int MEM_ADDR_W = 18;
  localparam int MASK_MSB   = 53;
  localparam int FRAME_BIT  = 49;
  localparam int ADDR_MSB   = 48;
  localparam int ADDR_LSB   = 32;
  localparam int PIX_MSB    = 31;
  typedef struct packed {
    logic [3:0]  mask;
    logic        frame;
    logic [16:0] addr;
    logic [31:0] pixel;
  } overlay_word_t;
endpackage

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: overlay word input, masked memory write port and frame status
interface fb_pixel_writer_if;
  logic [overlay_pkg::WORD_W-1:0]     din;
  logic                               din_valid;
  logic                               din_ready;
  logic [overlay_pkg::MEM_ADDR_W-1:0] mem_waddr;
  logic [31:0]                        mem_wdata;
  logic [3:0]                         mem_wmask;
  logic                               mem_wvalid;
  logic                               mem_wready;
  logic                               display_frame;
  logic                               frame_done;
  logic                               err_short;
  logic                               err_range;
  modport master (
    output din, din_valid, mem_wready,
    input  din_ready, mem_waddr, mem_wdata, mem_wmask, mem_wvalid,
    input  display_frame, frame_done, err_short, err_range
  );
  modport slave (
    input  din, din_valid, mem_wready,
    output din_ready, mem_waddr, mem_wdata, mem_wmask, mem_wvalid,
    output display_frame, frame_done, err_short, err_range
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered full/empty; a new entry becomes poppable one cycle after its write
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d, vis_d;
  logic          full_q, empty_q, do_push, do_pop;
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  // empty is judged on the count before this cycle's push, so it never over-reports
  assign vis_d   = cnt_q - {{AW{1'b0}}, do_pop};
  assign cnt_d   = vis_d + {{AW{1'b0}}, do_push};
  assign rdata_o = mem_q[rp_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= cnt_d == (AW+1)'(DEPTH);
      empty_q <= vis_d == '0;
    end
  end
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: buffers overlay words, issues masked framebuffer writes and publishes completed frames
module fb_pixel_writer
  import overlay_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int WORDS_PER_FRAME = 30000,
  parameter int MAX_ADDR        = 29999
) (
  input logic              clock,
  input logic              reset,
  fb_pixel_writer_if.slave bus
);
  localparam int CW = $clog2(WORDS_PER_FRAME + 1);
  overlay_word_t         head;
  logic                  full, empty, take, pop, in_range, load, last, fb_chg;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_n;
  logic                  cur_q, cur_d;
  logic                  ov_q, last_q, fin_q, fin_frame_q, done_q, disp_q;
  logic                  err_short_q, err_range_q;
  logic [MEM_ADDR_W-1:0] waddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wmask_q;
  sync_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (bus.din_valid),
    .pop_i   (pop),
    .wdata_i (bus.din),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign take     = ov_q & bus.mem_wready;
  assign pop      = ~empty & (~ov_q | take);
  assign in_range = 32'(head.addr) <= MAX_ADDR;
  assign load     = pop & in_range & |head.mask;
  assign fb_chg   = head.frame != cur_q;
  assign cnt_n    = fb_chg ? CW'(1) : (cnt_q == CW'(WORDS_PER_FRAME) ? cnt_q : cnt_q + 1'b1);
  assign last     = cnt_n == CW'(WORDS_PER_FRAME);
  assign cnt_d    = pop ? (last ? '0 : cnt_n) : cnt_q;
  assign cur_d    = pop ? head.frame : cur_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      ov_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      cur_q       <= 1'b1;
      fin_q       <= 1'b0;
      fin_frame_q <= 1'b0;
      done_q      <= 1'b0;
      disp_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      if (load) begin
        ov_q    <= 1'b1;
        waddr_q <= {head.frame, head.addr};
        wdata_q <= head.pixel;
        wmask_q <= head.mask;
        last_q  <= last;
      end else if (take) ov_q <= 1'b0;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      // completion waits until the frame's final word has left (written or dropped)
      fin_q       <= (take & last_q) | (pop & last & ~load);
      fin_frame_q <= (take & last_q) ? waddr_q[MEM_ADDR_W-1] : head.frame;
      done_q      <= fin_q;
      if (fin_q) disp_q <= fin_frame_q;
      err_short_q <= err_short_q | (pop & fb_chg & |cnt_q);
      err_range_q <= err_range_q | (pop & ~in_range);
    end
  end
  assign bus.din_ready     = ~full;
  assign bus.mem_wvalid    = ov_q;
  assign bus.mem_waddr     = waddr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.display_frame = disp_q;
  assign bus.frame_done    = done_q;
  assign bus.err_short     = err_short_q;
  assign bus.err_range     = err_range_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed checks on a full-size writer and a 4-word-frame writer
module tb_fb_pixel_writer;
  logic        clock = 1'b0;
  logic        reset, sel, din_valid, mem_wready;
  logic [53:0] din;
  logic        rdy, wv, fd, disp, e_short, e_range;
  logic [17:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  int          passed = 0, total = 0;
  int          cyc = 0, last_take = 0, fd_at = 0, fd_n = 0, acc = 0;
  logic [53:0] wlog [$];
  int          base, a0, f0;

  always #5 clock = ~clock;

  fb_pixel_writer_if ia ();
  fb_pixel_writer_if ib ();
  fb_pixel_writer u_big (.clock(clock), .reset(reset), .bus(ia));
  fb_pixel_writer #(.FIFO_DEPTH(8), .WORDS_PER_FRAME(4), .MAX_ADDR(3)) u_small (
    .clock(clock), .reset(reset), .bus(ib));

  assign ia.din        = din;
  assign ib.din        = din;
  assign ia.din_valid  = din_valid & ~sel;
  assign ib.din_valid  = din_valid & sel;
  assign ia.mem_wready = mem_wready;
  assign ib.mem_wready = mem_wready;
  assign rdy     = sel ? ib.din_ready     : ia.din_ready;
  assign wv      = sel ? ib.mem_wvalid    : ia.mem_wvalid;
  assign waddr   = sel ? ib.mem_waddr     : ia.mem_waddr;
  assign wdata   = sel ? ib.mem_wdata     : ia.mem_wdata;
  assign wmask   = sel ? ib.mem_wmask     : ia.mem_wmask;
  assign fd      = sel ? ib.frame_done    : ia.frame_done;
  assign disp    = sel ? ib.display_frame : ia.display_frame;
  assign e_short = sel ? ib.err_short     : ia.err_short;
  assign e_range = sel ? ib.err_range     : ia.err_range;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (wv & mem_wready) begin
      wlog.push_back({waddr, wdata, wmask});
      last_take <= cyc;
    end
    if (fd) begin
      fd_n  <= fd_n + 1;
      fd_at <= cyc;
    end
    if (din_valid & rdy) acc <= acc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [53:0] mkw(input logic [3:0] m, input logic f, input logic [16:0] a,
                                       input logic [31:0] p);
    return {m, f, a, p};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [53:0] w);
    int n = 0;
    @(negedge clock);
    din = w;
    din_valid = 1'b1;
    while (!rdy && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("accept", 64'(n < 100), 1);
    @(posedge clock);
    #1 din_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; din = '0; din_valid = 1'b0; mem_wready = 1'b0; reset = 1'b1;
    wait_cyc(3);
    chk("rst_ready", rdy, 0);
    chk("rst_wvalid", wv, 0);
    chk("rst_wfields", {waddr, wdata, wmask}, 0);
    chk("rst_status", {disp, fd, e_short, e_range}, 0);
    @(negedge clock) reset = 1'b0;
    #1 chk("ready_low_before_edge", rdy, 0);
    @(posedge clock);
    #1 chk("ready_after_reset", rdy, 1);

    send(mkw(4'hF, 1'b0, 17'd5, 32'hA1B2C3D4));
    @(posedge clock);
    #1 chk("lat_n1_wvalid", wv, 0);
    @(posedge clock);
    #1 chk("lat_n2_wvalid", wv, 1);
    chk("lat_waddr", waddr, 18'h00005);
    chk("lat_wmask", wmask, 4'hF);
    chk("lat_wdata", wdata, 32'hA1B2C3D4);
    mem_wready = 1'b1;
    wait_cyc(2);
    chk("first_taken", wlog.size(), 1);
    chk("first_wvalid_clear", wv, 0);

    send(mkw(4'h0, 1'b0, 17'd7, 32'h11111111));
    wait_cyc(4);
    chk("mask0_no_write", wlog.size(), 1);
    chk("mask0_no_err", e_range, 0);
    send(mkw(4'hF, 1'b0, 17'd30000, 32'h22222222));
    wait_cyc(4);
    chk("range_no_write", wlog.size(), 1);
    chk("range_err", e_range, 1);
    send(mkw(4'h3, 1'b1, 17'd29999, 32'h33333333));
    wait_cyc(4);
    chk("maxaddr_written", wlog.size(), 2);
    chk("maxaddr_entry", wlog[1], {1'b1, 17'd29999, 32'h33333333, 4'h3});
    chk("range_err_sticky", e_range, 1);

    mem_wready = 1'b0;
    wait_cyc(1);
    base = wlog.size();
    a0 = acc;
    fork
      for (int i = 0; i < 20; i++) send(mkw(4'hF, 1'b0, 17'(100 + i), 32'hC0DE0000 + i));
      begin
        wait_cyc(16);
        chk("bp_accepted", 64'(acc - a0), 9);
        chk("bp_ready_low", rdy, 0);
        chk("bp_wvalid_held", wv, 1);
        chk("bp_no_write", 64'(wlog.size() - base), 0);
        mem_wready = 1'b1;
      end
    join
    wait_cyc(30);
    chk("bp_count", 64'(wlog.size() - base), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("bp_order_%0d", i), wlog[base + i], {1'b0, 17'(100 + i), 32'hC0DE0000 + i, 4'hF});

    sel = 1'b1;
    wait_cyc(1);
    f0 = fd_n;
    for (int i = 0; i < 3; i++) send(mkw(4'hF, 1'b0, 17'(i), 32'h0F000000 + i));
    wait_cyc(5);
    chk("no_done_early", 64'(fd_n - f0), 0);
    send(mkw(4'hF, 1'b0, 17'd3, 32'h0F000003));
    wait_cyc(6);
    chk("frame0_done_once", 64'(fd_n - f0), 1);
    chk("frame0_done_after_take", 64'(fd_at - last_take), 2);
    chk("frame0_pulse_over", fd, 0);
    chk("frame0_display", disp, 0);
    for (int i = 0; i < 4; i++) send(mkw(4'hF, 1'b1, 17'(i), 32'h1F000000 + i));
    wait_cyc(6);
    chk("frame1_done", 64'(fd_n - f0), 2);
    chk("frame1_display", disp, 1);
    chk("frame1_no_short", e_short, 0);

    send(mkw(4'hF, 1'b0, 17'd0, 32'h20000000));
    send(mkw(4'hF, 1'b0, 17'd1, 32'h20000001));
    send(mkw(4'hF, 1'b1, 17'd0, 32'h21000000));
    wait_cyc(5);
    chk("short_err", e_short, 1);
    chk("short_no_done", 64'(fd_n - f0), 2);
    send(mkw(4'hF, 1'b1, 17'd1, 32'h21000001));
    send(mkw(4'hF, 1'b1, 17'd2, 32'h21000002));
    send(mkw(4'h0, 1'b1, 17'd3, 32'h21000003));
    wait_cyc(6);
    chk("restart_done_with_drop", 64'(fd_n - f0), 3);
    chk("restart_display", disp, 1);
    chk("short_err_sticky", e_short, 1);

    sel = 1'b0;
    mem_wready = 1'b0;
    wait_cyc(1);
    for (int i = 0; i < 6; i++) send(mkw(4'hF, 1'b0, 17'(200 + i), 32'h30000000 + i));
    wait_cyc(2);
    chk("midrst_wvalid_before", wv, 1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 chk("midrst_wvalid", wv, 0);
    chk("midrst_ready", rdy, 0);
    chk("midrst_err_range", e_range, 0);
    chk("midrst_small_status", {ib.err_short, ib.display_frame, ib.frame_done}, 0);
    base = wlog.size();
    mem_wready = 1'b1;
    @(negedge clock) reset = 1'b0;
    wait_cyc(12);
    chk("midrst_no_writes", 64'(wlog.size() - base), 0);
    chk("midrst_ready_back", rdy, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
